// File: rtl/spim_param_if.sv
// Request/response handshake and SPI pin bundle for spim_param.
// The master modport is the controller's view; slave is the requester/pin-side view.
interface spim_param_if #(
   parameter int DATA_W = 8,
   parameter int NUM_SS = 4
);
   localparam int SSW = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;

   logic              start;
   logic              ready;
   logic [1:0]        mode;
   logic              lsb_first;
   logic [SSW-1:0]    ss_sel;
   logic [DATA_W-1:0] txdata;
   logic [DATA_W-1:0] rxdata;
   logic              finish;
   logic              sclk;
   logic              mosi;
   logic [NUM_SS-1:0] ss_n;
   logic              miso;

   modport master (
      input  start, mode, lsb_first, ss_sel, txdata, miso,
      output ready, rxdata, finish, sclk, mosi, ss_n
   );

   modport slave (
      output start, mode, lsb_first, ss_sel, txdata, miso,
      input  ready, rxdata, finish, sclk, mosi, ss_n
   );
endinterface

// File: rtl/spim_param.sv
// Parameterised single-frame SPI master: all four modes, selectable bit order,
// one-hot active-low slave select, SCLK derived from clk by CLK_DIV.
module spim_param #(
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 2,
   parameter int NUM_SS  = 4
) (
   input  logic         clk,
   input  logic         rst,
   spim_param_if.master bus
);
   localparam int SSW    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;
   localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int EDGE_W = $clog2(2 * DATA_W + 1);

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

   state_t            state, state_nxt;
   logic [DIV_W-1:0]  div_cnt, div_cnt_nxt;
   logic [EDGE_W-1:0] edge_cnt, edge_cnt_nxt;
   logic              sclk_q, sclk_nxt;
   logic              mosi_q, mosi_nxt;
   logic              finish_q, finish_nxt;
   logic [NUM_SS-1:0] ss_n_q, ss_n_nxt;
   logic [DATA_W-1:0] tx_sh, tx_sh_nxt;
   logic [DATA_W-1:0] rx_sh, rx_sh_nxt;
   logic [DATA_W-1:0] rxdata_q, rxdata_nxt;
   logic              cpol, cpol_nxt;
   logic              cpha, cpha_nxt;
   logic              lsb, lsb_nxt;

   logic div_done;
   logic last_edge;
   logic leading;
   logic sample;
   logic drive;

   assign div_done  = (div_cnt == DIV_W'(CLK_DIV - 1));
   assign last_edge = (edge_cnt == EDGE_W'(2 * DATA_W - 1));
   // Edges are numbered from 0, so even-numbered toggles are leading edges.
   assign leading   = ~edge_cnt[0];
   assign sample    = leading ^ cpha;
   assign drive     = ~sample & ~last_edge;

   always_comb begin
      state_nxt    = state;
      div_cnt_nxt  = div_cnt;
      edge_cnt_nxt = edge_cnt;
      sclk_nxt     = sclk_q;
      mosi_nxt     = mosi_q;
      finish_nxt   = 1'b0;
      ss_n_nxt     = ss_n_q;
      tx_sh_nxt    = tx_sh;
      rx_sh_nxt    = rx_sh;
      rxdata_nxt   = rxdata_q;
      cpol_nxt     = cpol;
      cpha_nxt     = cpha;
      lsb_nxt      = lsb;

      unique case (state)
         IDLE: begin
            sclk_nxt = bus.mode[1];
            if (bus.start) begin
               state_nxt    = SETUP;
               div_cnt_nxt  = '0;
               edge_cnt_nxt = '0;
               cpol_nxt     = bus.mode[1];
               cpha_nxt     = bus.mode[0];
               lsb_nxt      = bus.lsb_first;
               rx_sh_nxt    = '0;
               tx_sh_nxt    = bus.txdata;
               for (int unsigned i = 0; i < NUM_SS; i++) begin
                  if (bus.ss_sel == SSW'(i)) ss_n_nxt[i] = 1'b0;
               end
               // CPHA=0 presents the first bit before any SCLK edge.
               if (!bus.mode[0]) begin
                  mosi_nxt  = bus.lsb_first ? bus.txdata[0] : bus.txdata[DATA_W-1];
                  tx_sh_nxt = bus.lsb_first ? (bus.txdata >> 1) : (bus.txdata << 1);
               end
            end
         end

         SETUP: begin
            div_cnt_nxt = div_cnt + 1'b1;
            if (div_done) begin
               div_cnt_nxt = '0;
               state_nxt   = SHIFT;
            end
         end

         SHIFT: begin
            div_cnt_nxt = div_cnt + 1'b1;
            if (div_done) begin
               div_cnt_nxt  = '0;
               sclk_nxt     = ~sclk_q;
               edge_cnt_nxt = edge_cnt + 1'b1;
               if (sample) begin
                  rx_sh_nxt = lsb ? {bus.miso, rx_sh[DATA_W-1:1]}
                                  : {rx_sh[DATA_W-2:0], bus.miso};
               end
               if (drive) begin
                  mosi_nxt  = lsb ? tx_sh[0] : tx_sh[DATA_W-1];
                  tx_sh_nxt = lsb ? (tx_sh >> 1) : (tx_sh << 1);
               end
               if (last_edge) state_nxt = HOLD;
            end
         end

         HOLD: begin
            sclk_nxt    = cpol;
            div_cnt_nxt = div_cnt + 1'b1;
            if (div_done) begin
               div_cnt_nxt = '0;
               state_nxt   = IDLE;
               rxdata_nxt  = rx_sh;
               finish_nxt  = 1'b1;
               ss_n_nxt    = '1;
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         div_cnt  <= '0;
         edge_cnt <= '0;
         sclk_q   <= 1'b0;
         mosi_q   <= 1'b0;
         finish_q <= 1'b0;
         ss_n_q   <= '1;
         tx_sh    <= '0;
         rx_sh    <= '0;
         rxdata_q <= '0;
         cpol     <= 1'b0;
         cpha     <= 1'b0;
         lsb      <= 1'b0;
      end else begin
         state    <= state_nxt;
         div_cnt  <= div_cnt_nxt;
         edge_cnt <= edge_cnt_nxt;
         sclk_q   <= sclk_nxt;
         mosi_q   <= mosi_nxt;
         finish_q <= finish_nxt;
         ss_n_q   <= ss_n_nxt;
         tx_sh    <= tx_sh_nxt;
         rx_sh    <= rx_sh_nxt;
         rxdata_q <= rxdata_nxt;
         cpol     <= cpol_nxt;
         cpha     <= cpha_nxt;
         lsb      <= lsb_nxt;
      end
   end

   assign bus.ready  = (state == IDLE);
   assign bus.sclk   = sclk_q;
   assign bus.mosi   = mosi_q;
   assign bus.ss_n   = ss_n_q;
   assign bus.finish = finish_q;
   assign bus.rxdata = rxdata_q;
endmodule

// File: tb/tb_spim_param.sv
// Directed self-checking bench for spim_param: default 8-bit/div-2/4-select build
// with an SPI slave model, plus a 16-bit/div-1/single-select build in loopback.
module tb_spim_param;
   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   spim_param_if #(.DATA_W(8),  .NUM_SS(4)) bus  ();
   spim_param_if #(.DATA_W(16), .NUM_SS(1)) bus2 ();

   spim_param #(.DATA_W(8),  .CLK_DIV(2), .NUM_SS(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
   spim_param #(.DATA_W(16), .CLK_DIV(1), .NUM_SS(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   assign bus2.miso = bus2.mosi;

   // Slave model: counts SCLK edges while selected, shifts its frame out on the
   // mode's launch edges and records mosi on the mode's capture edges.
   logic       loopback, s_cpha, s_lsb, prev_sclk;
   logic [7:0] sframe, mosi_seq;
   int         scnt, idx;

   always @(negedge clk) begin
      if (&bus.ss_n) scnt = 0;
      else if (bus.sclk !== prev_sclk) begin
         scnt = scnt + 1;
         if (((scnt % 2) == 1) != s_cpha) mosi_seq = {mosi_seq[6:0], bus.mosi};
      end
      prev_sclk = bus.sclk;
      if (s_cpha) idx = (scnt == 0) ? 0 : (scnt - 1) / 2;
      else        idx = scnt / 2;
      if (idx > 7) idx = 7;
      bus.miso = loopback ? bus.mosi : sframe[s_lsb ? idx : 7 - idx];
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs go up one cycle ahead so idle SCLK settles to the new CPOL; after the
   // accept edge they are scrambled to show the request was latched.
   task automatic xfer(input logic [1:0] m, input logic l, input logic [1:0] sel,
                       input logic [7:0] tx, input logic [3:0] exp_ss,
                       output int fin_edge, output logic [7:0] rx);
      bus.mode = m; bus.lsb_first = l; bus.ss_sel = sel; bus.txdata = tx;
      tick;
      chk("ready_idle", bus.ready, 1);
      chk("sclk_idle", bus.sclk, m[1]);
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      bus.mode = ~m; bus.lsb_first = ~l; bus.ss_sel = sel + 2'd1; bus.txdata = ~tx;
      chk("ss_n_accept", bus.ss_n, exp_ss);
      chk("ready_busy", bus.ready, 0);
      fin_edge = -1;
      rx = 'x;
      for (int e = 1; e <= 60; e++) begin
         tick;
         if (bus.finish === 1'b1) begin
            fin_edge = e;
            rx = bus.rxdata;
            break;
         end
      end
   endtask

   int          fe, f1, f2, hi, nofin;
   logic [7:0]  rx, rx1, rx2;
   logic [15:0] rxw;

   initial begin
      rst = 1'b1;
      bus.start = 1'b0; bus.mode = 2'd0; bus.lsb_first = 1'b0; bus.ss_sel = '0; bus.txdata = '0;
      bus2.start = 1'b0; bus2.mode = 2'd0; bus2.lsb_first = 1'b0; bus2.ss_sel = '0; bus2.txdata = '0;
      loopback = 1'b1; s_cpha = 1'b0; s_lsb = 1'b0; sframe = '0; mosi_seq = '0;
      repeat (3) tick;
      chk("rst_ready", bus.ready, 1);
      chk("rst_ss_n", bus.ss_n, 4'hF);
      chk("rst_sclk", bus.sclk, 0);
      chk("rst_mosi", bus.mosi, 0);
      chk("rst_rxdata", bus.rxdata, 0);
      chk("rst_finish", bus.finish, 0);
      rst = 1'b0;

      // Mode 0, MSB first, loopback: finish visible just after edge 36 (cycle 37).
      xfer(2'd0, 1'b0, 2'd0, 8'hA5, 4'b1110, fe, rx);
      chk("m0_fin_edge", fe, 36);
      chk("m0_rx", rx, 8'hA5);
      chk("m0_mosi_seq", mosi_seq, 8'hA5);

      // Mode 3, LSB first, slave returns 0x96.
      loopback = 1'b0; s_cpha = 1'b1; s_lsb = 1'b1; sframe = 8'h96;
      xfer(2'd3, 1'b1, 2'd2, 8'h3C, 4'b1011, fe, rx);
      chk("m3_fin_edge", fe, 36);
      chk("m3_rx", rx, 8'h96);
      chk("m3_mosi_seq", mosi_seq, 8'b0011_1100);
      chk("m3_sclk_hold", bus.sclk, 1);
      chk("m3_ss_n_end", bus.ss_n, 4'hF);
      repeat (3) tick;
      chk("rx_holds", bus.rxdata, 8'h96);
      chk("finish_pulse", bus.finish, 0);

      // Modes 1 and 2, MSB first, slave returns 0xC3.
      s_cpha = 1'b1; s_lsb = 1'b0; sframe = 8'hC3;
      xfer(2'd1, 1'b0, 2'd1, 8'h5A, 4'b1101, fe, rx);
      chk("m1_fin_edge", fe, 36);
      chk("m1_rx", rx, 8'hC3);
      chk("m1_mosi_seq", mosi_seq, 8'h5A);
      s_cpha = 1'b0;
      xfer(2'd2, 1'b0, 2'd3, 8'h5A, 4'b0111, fe, rx);
      chk("m2_fin_edge", fe, 36);
      chk("m2_rx", rx, 8'hC3);
      chk("m2_mosi_seq", mosi_seq, 8'h5A);
      chk("m2_sclk_hold", bus.sclk, 1);

      // Back-to-back with start held: second request accepted in the finish cycle.
      loopback = 1'b1; s_cpha = 1'b0; s_lsb = 1'b0;
      bus.mode = 2'd0; bus.lsb_first = 1'b0; bus.ss_sel = 2'd0; bus.txdata = 8'h11;
      tick;
      bus.start = 1'b1;
      tick;
      bus.txdata = 8'h22;
      f1 = -1; f2 = -1; hi = 0; rx1 = '0; rx2 = '0;
      for (int e = 1; e <= 90; e++) begin
         tick;
         if (bus.finish === 1'b1) begin
            if (f1 < 0) begin
               f1 = e; rx1 = bus.rxdata;
            end else if (f2 < 0) begin
               f2 = e; rx2 = bus.rxdata; bus.start = 1'b0;
            end
         end
         if (f1 >= 0 && f2 < 0 && (&bus.ss_n)) hi++;
      end
      bus.start = 1'b0;
      chk("b2b_first_edge", f1, 36);
      chk("b2b_spacing", f2 - f1, 37);
      chk("b2b_rx1", rx1, 8'h11);
      chk("b2b_rx2", rx2, 8'h22);
      chk("b2b_ss_gap", hi, 1);

      // Reset during cycle 15 of a mode-3 transfer.
      s_cpha = 1'b1;
      bus.mode = 2'd3; bus.lsb_first = 1'b0; bus.ss_sel = 2'd1; bus.txdata = 8'hFF;
      tick;
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      repeat (14) tick;
      chk("pre_rst_mosi", bus.mosi, 1);
      rst = 1'b1;
      tick;
      chk("mid_rst_ss_n", bus.ss_n, 4'hF);
      chk("mid_rst_sclk", bus.sclk, 0);
      chk("mid_rst_mosi", bus.mosi, 0);
      chk("mid_rst_rxdata", bus.rxdata, 0);
      chk("mid_rst_finish", bus.finish, 0);
      chk("mid_rst_ready", bus.ready, 1);
      chk("mid_rst_ss_n2", bus2.ss_n, 1'b1);
      rst = 1'b0;
      tick;
      chk("post_rst_cpol", bus.sclk, 1);
      nofin = 0;
      repeat (40) begin
         tick;
         if (bus.finish !== 1'b0) nofin++;
      end
      chk("no_finish_after_rst", nofin, 0);
      xfer(2'd3, 1'b0, 2'd1, 8'hFF, 4'b1101, fe, rx);
      chk("rst_then_fin_edge", fe, 36);
      chk("rst_then_rx", rx, 8'hFF);

      // 16-bit, CLK_DIV=1, single select: finish visible just after edge 34 (cycle 35).
      bus2.mode = 2'd0; bus2.lsb_first = 1'b0; bus2.ss_sel = '0; bus2.txdata = 16'hBEEF;
      tick;
      bus2.start = 1'b1;
      tick;
      bus2.start = 1'b0;
      bus2.txdata = 16'h0000;
      chk("w16_ss_n", bus2.ss_n, 1'b0);
      fe = -1; rxw = '0;
      for (int e = 1; e <= 60; e++) begin
         tick;
         if (bus2.finish === 1'b1) begin
            fe = e; rxw = bus2.rxdata;
            break;
         end
      end
      chk("w16_fin_edge", fe, 34);
      chk("w16_rx", rxw, 16'hBEEF);
      chk("w16_ss_n_end", bus2.ss_n, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
